// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle-MUL control unit: RISC-V opcode and
// funct7 encodings, alu_op codes, the FSM state type and the control bundle.
package ctrl_pkg;

  // Major opcodes (instr[6:0]) recognised by the decoder.
  localparam logic [6:0] ALU_R     = 7'b0110011;
  localparam logic [6:0] ALU_I     = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH_EQ = 7'b1100011;
  localparam logic [6:0] JUMP      = 7'b1101111;

  // funct7 (instr[31:25]) values that are legal under ALU_R.
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // alu_op encodings driven towards the ALU control.
  localparam logic [1:0] ADD    = 2'b00;
  localparam logic [1:0] SUB    = 2'b01;
  localparam logic [1:0] R_TYPE = 2'b10;
  localparam logic [1:0] MULT   = 2'b11;

  // RUN decodes normally; MUL_WAIT holds the pipe until the multiplier is
  // done; MUL_WB is the single writeback cycle of a MUL.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MUL_WAIT = 2'b01,
    MUL_WB   = 2'b10
  } state_t;

  // Datapath control bundle shared by the decoder and the output mux.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Bundle used in every cycle owned by an in-flight MUL (start and wait).
  function automatic ctrl_t ctrl_mul_hold();
    ctrl_t c;
    c        = CTRL_NONE;
    c.alu_op = MULT;
    return c;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Purely combinational RUN-state decode table: opcode/funct7 to the control
// bundle, plus flags for a MUL (handled by the FSM) and undecodable encodings.
module control_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_2_reg,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_write,
  output logic       jump,
  output logic       is_mul,
  output logic       illegal
);

  ctrl_t ctl;

  // Decode table; anything not explicitly set stays 0, reg_dst is never used.
  always_comb begin
    ctl     = CTRL_NONE;
    is_mul  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      ALU_R: begin
        if ((funct7 == F7_BASE) || (funct7 == F7_ALT)) begin
          ctl.alu_src   = 1'b0;
          ctl.reg_write = 1'b1;
          ctl.alu_op    = R_TYPE;
        end else if (funct7 == F7_MULDIV) begin
          // MUL writes back later, from MUL_WB, not in the decode cycle.
          is_mul = 1'b1;
          ctl    = ctrl_mul_hold();
        end else begin
          illegal = 1'b1;
        end
      end
      ALU_I: begin
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.alu_op    = ADD;
      end
      LOAD: begin
        ctl.alu_src   = 1'b1;
        ctl.mem_2_reg = 1'b1;
        ctl.mem_read  = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.alu_op    = ADD;
      end
      STORE: begin
        ctl.alu_src   = 1'b1;
        ctl.mem_write = 1'b1;
        ctl.alu_op    = ADD;
      end
      BRANCH_EQ: begin
        ctl.branch = 1'b1;
        ctl.alu_op = SUB;
      end
      JUMP: begin
        ctl.jump   = 1'b1;
        ctl.alu_op = ADD;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign alu_op    = ctl.alu_op;
  assign reg_dst   = ctl.reg_dst;
  assign branch    = ctl.branch;
  assign mem_read  = ctl.mem_read;
  assign mem_2_reg = ctl.mem_2_reg;
  assign mem_write = ctl.mem_write;
  assign alu_src   = ctl.alu_src;
  assign reg_write = ctl.reg_write;
  assign jump      = ctl.jump;

endmodule

// File: rtl/control_unit_mc.sv
// RISC-V control unit with stall support for a multi-cycle multiplier.
// Wraps the combinational decoder with a RUN/MUL_WAIT/MUL_WB FSM, a bounded
// wait counter and a sticky timeout flag.
// Optional build macro MUL_STALL_CNT_EN adds the mul_stall_cycles counter.
module control_unit_mc
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 2,
  parameter int MUL_TIMEOUT = 64,
  // Derived from MUL_TIMEOUT; leave at its default.
  parameter int CNT_W       = $clog2(MUL_TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                instr_valid,
  input  logic [6:0]          opcode,
  input  logic [6:0]          funct7,
  input  logic                mul_done,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_dst,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_2_reg,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_write,
  output logic                jump,
  output logic                mul_start,
  output logic                stall,
  output logic                illegal_instr,
  output logic                mul_timeout
`ifdef MUL_STALL_CNT_EN
  ,
  output logic [31:0]         mul_stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;

  ctrl_t dec_ctl;
  logic  dec_is_mul;
  logic  dec_illegal;
  ctrl_t out_ctl;

  control_decoder u_decoder (
    .opcode    (opcode),
    .funct7    (funct7),
    .alu_op    (dec_ctl.alu_op),
    .reg_dst   (dec_ctl.reg_dst),
    .branch    (dec_ctl.branch),
    .mem_read  (dec_ctl.mem_read),
    .mem_2_reg (dec_ctl.mem_2_reg),
    .mem_write (dec_ctl.mem_write),
    .alu_src   (dec_ctl.alu_src),
    .reg_write (dec_ctl.reg_write),
    .jump      (dec_ctl.jump),
    .is_mul    (dec_is_mul),
    .illegal   (dec_illegal)
  );

  // State register: reset also abandons any MUL in flight.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state logic; mul_done only matters in MUL_WAIT and beats the timeout.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      RUN: begin
        if (instr_valid && dec_is_mul) begin
          state_next = MUL_WAIT;
          cnt_next   = '0;
        end
      end
      MUL_WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (mul_done) begin
          state_next = MUL_WB;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = RUN;
          timeout_next = 1'b1;
        end
      end
      MUL_WB: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Output logic; everything is held at 0 while reset is asserted.
  always_comb begin
    out_ctl       = CTRL_NONE;
    mul_start     = 1'b0;
    stall         = 1'b0;
    illegal_instr = 1'b0;
    if (arst_n) begin
      case (state_reg)
        RUN: begin
          if (instr_valid) begin
            out_ctl       = dec_ctl;
            mul_start     = dec_is_mul;
            stall         = dec_is_mul;
            illegal_instr = dec_illegal;
          end
        end
        MUL_WAIT: begin
          out_ctl = ctrl_mul_hold();
          stall   = 1'b1;
        end
        MUL_WB: begin
          out_ctl           = ctrl_mul_hold();
          out_ctl.reg_write = 1'b1;
        end
        default: begin
          out_ctl = CTRL_NONE;
        end
      endcase
    end
  end

  assign alu_op      = ALU_OP_W'(out_ctl.alu_op);
  assign reg_dst     = out_ctl.reg_dst;
  assign branch      = out_ctl.branch;
  assign mem_read    = out_ctl.mem_read;
  assign mem_2_reg   = out_ctl.mem_2_reg;
  assign mem_write   = out_ctl.mem_write;
  assign alu_src     = out_ctl.alu_src;
  assign reg_write   = out_ctl.reg_write;
  assign jump        = out_ctl.jump;
  assign mul_timeout = arst_n & timeout_reg;

`ifdef MUL_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Saturating count of every cycle in which the front end is frozen.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign mul_stall_cycles = arst_n ? stall_cnt_reg : 32'd0;
`endif

endmodule

// File: tb/tb_control_unit_mc.sv
// Self-checking bench for control_unit_mc (built with MUL_TIMEOUT=8).
// Table-driven decode vectors plus hand-written multi-cycle MUL sequences.
module tb_control_unit_mc;

  // Encodings written out independently of the design package.
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;
  localparam logic [6:0] F_BASE = 7'b0000000;
  localparam logic [6:0] F_ALT  = 7'b0100000;
  localparam logic [6:0] F_MUL  = 7'b0000001;
  localparam logic [6:0] F_BAD  = 7'b0000010;

  // Observed vector: {alu_op, reg_dst, branch, mem_read, mem_2_reg, mem_write,
  //                   alu_src, reg_write, jump, mul_start, stall, illegal, timeout}
  localparam logic [13:0] TO    = 14'h0001;
  localparam logic [13:0] IL    = 14'h0002;
  localparam logic [13:0] ST    = 14'h0004;
  localparam logic [13:0] MS    = 14'h0008;
  localparam logic [13:0] J     = 14'h0010;
  localparam logic [13:0] RW    = 14'h0020;
  localparam logic [13:0] AS    = 14'h0040;
  localparam logic [13:0] MW    = 14'h0080;
  localparam logic [13:0] M2R   = 14'h0100;
  localparam logic [13:0] MR    = 14'h0200;
  localparam logic [13:0] BR    = 14'h0400;
  localparam logic [13:0] A_SUB = 14'h1000;
  localparam logic [13:0] A_R   = 14'h2000;
  localparam logic [13:0] A_MUL = 14'h3000;
  localparam logic [13:0] NONE  = 14'h0000;

  localparam logic [13:0] E_LOAD = MR | M2R | AS | RW;
  localparam logic [13:0] E_RTYP = A_R | RW;
  localparam logic [13:0] E_ALUI = AS | RW;
  localparam logic [13:0] E_STOR = AS | MW;
  localparam logic [13:0] E_BEQ  = BR | A_SUB;
  localparam logic [13:0] E_JAL  = J;
  localparam logic [13:0] E_MSTA = MS | ST | A_MUL;
  localparam logic [13:0] E_MWT  = ST | A_MUL;
  localparam logic [13:0] E_MWB  = RW | A_MUL;

  logic        clk;
  logic        arst_n;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic        mul_done;
  logic [1:0]  alu_op;
  logic        reg_dst, branch, mem_read, mem_2_reg, mem_write;
  logic        alu_src, reg_write, jump, mul_start, stall;
  logic        illegal_instr, mul_timeout;
`ifdef MUL_STALL_CNT_EN
  logic [31:0] mul_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  control_unit_mc #(
    .ALU_OP_W    (2),
    .MUL_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .funct7        (funct7),
    .mul_done      (mul_done),
    .alu_op        (alu_op),
    .reg_dst       (reg_dst),
    .branch        (branch),
    .mem_read      (mem_read),
    .mem_2_reg     (mem_2_reg),
    .mem_write     (mem_write),
    .alu_src       (alu_src),
    .reg_write     (reg_write),
    .jump          (jump),
    .mul_start     (mul_start),
    .stall         (stall),
    .illegal_instr (illegal_instr),
    .mul_timeout   (mul_timeout)
`ifdef MUL_STALL_CNT_EN
    ,
    .mul_stall_cycles (mul_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] obs;
  assign obs = {alu_op, reg_dst, branch, mem_read, mem_2_reg, mem_write,
                alu_src, reg_write, jump, mul_start, stall, illegal_instr, mul_timeout};

  typedef struct {
    string       name;
    logic        rst_n;
    logic        valid;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic        done;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[14];

  // One clock cycle: drive, let the decode settle, compare mid-cycle, advance.
  task automatic cyc(input string name, input logic r, input logic v,
                     input logic [6:0] o, input logic [6:0] f, input logic d,
                     input logic [13:0] e);
    arst_n      = r;
    instr_valid = v;
    opcode      = o;
    funct7      = f;
    mul_done    = d;
    #4;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, obs, e);
    end else begin
      $display("ok   %s: %h", name, obs);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n      = 1'b0;
    instr_valid = 1'b0;
    opcode      = 7'd0;
    funct7      = 7'd0;
    mul_done    = 1'b0;

    vecs[0]  = '{"rst0_load",   1'b0, 1'b1, OP_LD,  F_BASE, 1'b0, NONE};
    vecs[1]  = '{"rst1_load",   1'b0, 1'b1, OP_LD,  F_BASE, 1'b0, NONE};
    vecs[2]  = '{"load",        1'b1, 1'b1, OP_LD,  F_BASE, 1'b0, E_LOAD};
    vecs[3]  = '{"rtype_add",   1'b1, 1'b1, OP_R,   F_BASE, 1'b0, E_RTYP};
    vecs[4]  = '{"rtype_sub",   1'b1, 1'b1, OP_R,   F_ALT,  1'b0, E_RTYP};
    vecs[5]  = '{"alu_i",       1'b1, 1'b1, OP_I,   F_ALT,  1'b0, E_ALUI};
    vecs[6]  = '{"store",       1'b1, 1'b1, OP_ST,  F_BASE, 1'b0, E_STOR};
    vecs[7]  = '{"branch_eq",   1'b1, 1'b1, OP_BEQ, F_BASE, 1'b0, E_BEQ};
    vecs[8]  = '{"jump",        1'b1, 1'b1, OP_JAL, F_BASE, 1'b0, E_JAL};
    vecs[9]  = '{"bubble_r",    1'b1, 1'b0, OP_R,   F_BASE, 1'b0, NONE};
    vecs[10] = '{"bubble_mul",  1'b1, 1'b0, OP_R,   F_MUL,  1'b0, NONE};
    vecs[11] = '{"ill_funct7",  1'b1, 1'b1, OP_R,   F_BAD,  1'b0, IL};
    vecs[12] = '{"ill_opcode",  1'b1, 1'b1, OP_BAD, F_BASE, 1'b0, IL};
    vecs[13] = '{"stray_done",  1'b1, 1'b0, OP_R,   F_BASE, 1'b1, NONE};

    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].name, vecs[i].rst_n, vecs[i].valid, vecs[i].opc,
          vecs[i].f7, vecs[i].done, vecs[i].exp);
    end

    // MUL finishing after three wait cycles, then writeback, then back to RUN.
    cyc("mul1_start", 1'b1, 1'b1, OP_R, F_MUL, 1'b0, E_MSTA);
    cyc("mul1_wait1", 1'b1, 1'b1, OP_R, F_MUL, 1'b0, E_MWT);
    cyc("mul1_wait2", 1'b1, 1'b1, OP_R, F_MUL, 1'b0, E_MWT);
    cyc("mul1_wait3", 1'b1, 1'b1, OP_R, F_MUL, 1'b1, E_MWT);
    cyc("mul1_wb",    1'b1, 1'b1, OP_I, F_BASE, 1'b0, E_MWB);
    cyc("mul1_next",  1'b1, 1'b1, OP_I, F_BASE, 1'b0, E_ALUI);

    // A done pulse coinciding with mul_start must not skip MUL_WAIT.
    cyc("mul2_start_done", 1'b1, 1'b1, OP_R, F_MUL, 1'b1, E_MSTA);
    cyc("mul2_wait_done",  1'b1, 1'b1, OP_R, F_MUL, 1'b1, E_MWT);
    cyc("mul2_wb",         1'b1, 1'b1, OP_R, F_BASE, 1'b0, E_MWB);
    cyc("mul2_next",       1'b1, 1'b1, OP_R, F_BASE, 1'b0, E_RTYP);

    // No done at all: eight wait cycles, then RUN with the sticky flag set.
    cyc("mul3_start", 1'b1, 1'b1, OP_R, F_MUL, 1'b0, E_MSTA);
    for (int w = 0; w < 8; w++) begin
      cyc($sformatf("mul3_wait%0d", w + 1), 1'b1, 1'b1, OP_R, F_MUL, 1'b0, E_MWT);
    end
    cyc("mul3_after_to", 1'b1, 1'b1, OP_R, F_BASE, 1'b0, E_RTYP | TO);
    cyc("mul3_sticky",   1'b1, 1'b1, OP_I, F_BASE, 1'b0, E_ALUI | TO);

`ifdef MUL_STALL_CNT_EN
    // Stalled so far: 4 (mul1) + 2 (mul2) + 9 (mul3).
    checks++;
    if (mul_stall_cycles !== 32'd15) begin
      errors++;
      $display("FAIL stall_cnt_15: got %0d want 15", mul_stall_cycles);
    end else begin
      $display("ok   stall_cnt_15: %0d", mul_stall_cycles);
    end
`endif

    // Reset during MUL_WAIT abandons the MUL; a late done is ignored.
    cyc("mul4_start",    1'b1, 1'b1, OP_R, F_MUL, 1'b0, E_MSTA | TO);
    cyc("mul4_wait",     1'b1, 1'b1, OP_R, F_MUL, 1'b0, E_MWT | TO);
    cyc("mul4_rst",      1'b0, 1'b1, OP_R, F_MUL, 1'b0, NONE);
`ifdef MUL_STALL_CNT_EN
    checks++;
    if (mul_stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL stall_cnt_rst: got %0d want 0", mul_stall_cycles);
    end else begin
      $display("ok   stall_cnt_rst: %0d", mul_stall_cycles);
    end
`endif
    cyc("mul4_late_done", 1'b1, 1'b0, OP_R, F_MUL, 1'b1, NONE);
    cyc("mul4_idle",      1'b1, 1'b0, OP_R, F_MUL, 1'b0, NONE);
    cyc("mul4_load",      1'b1, 1'b1, OP_LD, F_BASE, 1'b0, E_LOAD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
